// File: rtl/simon_pkg.sv
// SIMON key-schedule constants, FSM state type and standard variant parameters
// shared by the round-key sequencer and its combinational round.
package simon_pkg;

   localparam logic [61:0] Z0 = 62'b11111_01000_10010_10110_00011_10011_01111_10100_01001_01011_00001_11001_10;
   localparam logic [61:0] Z1 = 62'b10001_11011_11100_10011_00001_01101_01000_11101_11110_01001_10000_10110_10;
   localparam logic [61:0] Z2 = 62'b10101_11101_11000_00011_01001_00110_00101_00001_00011_11110_01011_01100_11;
   localparam logic [61:0] Z3 = 62'b11011_01110_10110_00110_01011_11000_00010_01000_10100_11100_11010_00011_11;
   localparam logic [61:0] Z4 = 62'b11010_00111_10011_01011_01100_01000_00010_11100_00110_01010_01001_11011_11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_t;

   // Standard variants as (N, M, T, ZSEL)
   localparam int SIMON_32_64_N   = 16, SIMON_32_64_M   = 4, SIMON_32_64_T   = 32, SIMON_32_64_Z   = 0;
   localparam int SIMON_48_72_N   = 24, SIMON_48_72_M   = 3, SIMON_48_72_T   = 36, SIMON_48_72_Z   = 0;
   localparam int SIMON_48_96_N   = 24, SIMON_48_96_M   = 4, SIMON_48_96_T   = 36, SIMON_48_96_Z   = 1;
   localparam int SIMON_64_96_N   = 32, SIMON_64_96_M   = 3, SIMON_64_96_T   = 42, SIMON_64_96_Z   = 2;
   localparam int SIMON_64_128_N  = 32, SIMON_64_128_M  = 4, SIMON_64_128_T  = 44, SIMON_64_128_Z  = 3;
   localparam int SIMON_96_96_N   = 48, SIMON_96_96_M   = 2, SIMON_96_96_T   = 52, SIMON_96_96_Z   = 2;
   localparam int SIMON_96_144_N  = 48, SIMON_96_144_M  = 3, SIMON_96_144_T  = 54, SIMON_96_144_Z  = 3;
   localparam int SIMON_128_128_N = 64, SIMON_128_128_M = 2, SIMON_128_128_T = 68, SIMON_128_128_Z = 2;
   localparam int SIMON_128_192_N = 64, SIMON_128_192_M = 3, SIMON_128_192_T = 69, SIMON_128_192_Z = 3;
   localparam int SIMON_128_256_N = 64, SIMON_128_256_M = 4, SIMON_128_256_T = 72, SIMON_128_256_Z = 4;

   // Bit k of sequence s; bit 0 is the leftmost character of the published string.
   function automatic logic z_bit(input int unsigned s, input logic [6:0] k);
      logic [61:0] z;
      logic [5:0]  idx;
      case (s)
         0:       z = Z0;
         1:       z = Z1;
         2:       z = Z2;
         3:       z = Z3;
         default: z = Z4;
      endcase
      idx = 6'(k % 7'd62);
      return z[6'd61 - idx];
   endfunction

   // Round constant 2^n - 4, returned zero-extended to 64 bits
   function automatic logic [63:0] round_const(input int n);
      if (n >= 64)
         return ~64'd3;
      return ((64'd1 << n) - 64'd1) & ~64'd3;
   endfunction

endpackage

// File: rtl/simon_key_round.sv
// One step of the SIMON key-expansion recurrence: produces the key M positions
// ahead of w0 from the current key window and the round's z bit.
module simon_key_round
   import simon_pkg::*;
#(
   parameter int N = 48,
   parameter int M = 2
) (
   input  logic [N-1:0] w0,
   input  logic [N-1:0] w1,
   input  logic [N-1:0] w_last,
   input  logic         z,
   output logic [N-1:0] knew
);

   localparam logic [N-1:0] C = N'(round_const(N));

   logic [N-1:0] t_rot3;
   logic [N-1:0] t_mix;
   logic [N-1:0] t_fold;

   always_comb begin
      t_rot3 = {w_last[2:0], w_last[N-1:3]};
      t_mix  = (M == 4) ? (t_rot3 ^ w1) : t_rot3;
      t_fold = t_mix ^ {t_mix[0], t_mix[N-1:1]};
      knew   = C ^ w0 ^ t_fold ^ {{(N-1){1'b0}}, z};
   end

endmodule

// File: rtl/simon_key_sequencer.sv
// Streams T SIMON round keys from an N*M-bit master key, one per valid/ready
// transfer, using an M-word shift register fed by simon_key_round.
//
// state   | meaning
// ST_IDLE | waiting for start; outputs quiet
// ST_RUN  | w[0] presented as round key cnt, shifts on each accepted transfer
module simon_key_sequencer
   import simon_pkg::*;
#(
   parameter int N    = 48,
   parameter int M    = 2,
   parameter int T    = 52,
   parameter int ZSEL = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N*M-1:0] key,
   output logic           busy,
   output logic           rk_valid,
   input  logic           rk_ready,
   output logic [N-1:0]   rk_data,
   output logic [6:0]     rk_idx,
   output logic           rk_last,
   output logic           done
);

   generate
      if (M < 2 || M > 4) begin : g_bad_m
         $error("simon_key_sequencer: M must be 2, 3 or 4");
      end
      if (T < M || T > 127) begin : g_bad_t
         $error("simon_key_sequencer: T must lie in M..127");
      end
      if (ZSEL < 0 || ZSEL > 4) begin : g_bad_z
         $error("simon_key_sequencer: ZSEL must lie in 0..4");
      end
   endgenerate

   localparam logic [6:0] LAST_IDX = 7'(T - 1);

   seq_state_t   state, state_nxt;
   logic [6:0]   cnt;
   logic [N-1:0] w [M];
   logic         load, xfer, last_xfer;
   logic         done_q;
   logic         z_cur;
   logic [N-1:0] knew;

   assign z_cur = z_bit(ZSEL, cnt);

   simon_key_round #(.N(N), .M(M)) u_round (
      .w0     (w[0]),
      .w1     (w[1]),
      .w_last (w[M-1]),
      .z      (z_cur),
      .knew   (knew)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
         for (int j = 0; j < M; j++)
            w[j] <= '0;
      end else begin
         state  <= state_nxt;
         done_q <= last_xfer;
         if (load) begin
            cnt <= '0;
            for (int j = 0; j < M; j++)
               w[j] <= key[j*N +: N];
         end else if (xfer) begin
            cnt <= cnt + 7'd1;
            for (int j = 0; j < M-1; j++)
               w[j] <= w[j+1];
            w[M-1] <= knew;
         end
      end
   end

   // start is only looked at in IDLE, so a start during the final transfer is dropped
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      xfer      = 1'b0;
      last_xfer = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (rk_ready) begin
               xfer = 1'b1;
               if (cnt == LAST_IDX) begin
                  last_xfer = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy     = (state == ST_RUN);
   assign rk_valid = busy;
   assign rk_data  = busy ? w[0] : '0;
   assign rk_idx   = busy ? cnt : '0;
   assign rk_last  = busy && (cnt == LAST_IDX);
   assign done     = done_q;

endmodule
